edge_frame_reader: RTL and testbench

Read-side counterpart of the Sobel edge write path. Edge magnitudes are produced as 12-bit words and stored to SDRAM; this block pulls them back out of the SDRAM read-port FIFO on display demand. It converts each word to 10-bit RGB for the VGA controller, tracks frame position, and flags FIFO underflow. It sits between the SDRAM read FIFO and the VGA display controller.

---
 rtl/edge_frame_reader.sv | 113 +++++++++++
 tb/tb_edge_frame_reader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_frame_reader.sv
// rtl/edge_frame_reader.sv - SDRAM edge-magnitude FIFO reader feeding the VGA pixel path
// Optional binarized output selected by defining EDGE_THRESH_EN.
module edge_frame_reader #(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter logic [11:0] THRESH   = 12'd256,
  localparam int         XW       = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
  localparam int         YW       = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iFrameStart,
  input  logic          iPixReq,
  output logic          oFifoRd,
  input  logic [15:0]   iFifoData,
  input  logic          iFifoEmpty,
  output logic [9:0]    oRed,
  output logic [9:0]    oGreen,
  output logic [9:0]    oBlue,
  output logic          oDVAL,
  output logic [XW-1:0] oX,
  output logic [YW-1:0] oY,
  output logic          oUnderflow,
  output logic          oFrameDone
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic [1:0]    state;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic          accepted;
  logic          last_pix;
  logic          pend_valid;
  logic          pend_black;
  logic [9:0]    pix;
  logic          unused_bits;

  assign accepted = iPixReq && (state == ST_ACTIVE) && !iFrameStart;
  assign last_pix = (x_cnt == X_LAST) && (y_cnt == Y_LAST);
  assign oFifoRd  = accepted && !iFifoEmpty;
  assign oX       = x_cnt;
  assign oY       = y_cnt;

`ifdef EDGE_THRESH_EN
  assign pix         = (iFifoData[11:0] >= THRESH) ? 10'h3FF : 10'h000;
  assign unused_bits = ^iFifoData[15:12];
`else
  assign pix         = iFifoData[11:2];
  assign unused_bits = ^{iFifoData[15:12], iFifoData[1:0], THRESH};
`endif

  // Frame position, state and sticky underflow; frame start wins over any request.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state      <= ST_IDLE;
      x_cnt      <= '0;
      y_cnt      <= '0;
      oUnderflow <= 1'b0;
      oFrameDone <= 1'b0;
    end else begin
      oFrameDone <= 1'b0;
      if (iFrameStart) begin
        state      <= ST_ACTIVE;
        x_cnt      <= '0;
        y_cnt      <= '0;
        oUnderflow <= 1'b0;
      end else if (accepted) begin
        if (iFifoEmpty) begin
          oUnderflow <= 1'b1;
        end
        if (last_pix) begin
          state      <= ST_DONE;
          x_cnt      <= '0;
          y_cnt      <= '0;
          oFrameDone <= 1'b1;
        end else if (x_cnt == X_LAST) begin
          x_cnt <= '0;
          y_cnt <= y_cnt + YW'(1);
        end else begin
          x_cnt <= x_cnt + XW'(1);
        end
      end
    end
  end

  // Two-stage pixel pipeline: FIFO data arrives the cycle after the strobe.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      pend_valid <= 1'b0;
      pend_black <= 1'b0;
      oDVAL      <= 1'b0;
      oRed       <= '0;
      oGreen     <= '0;
      oBlue      <= '0;
    end else begin
      pend_valid <= accepted;
      pend_black <= accepted && iFifoEmpty;
      oDVAL      <= pend_valid;
      if (pend_valid) begin
        oRed   <= pend_black ? 10'h000 : pix;
        oGreen <= pend_black ? 10'h000 : pix;
        oBlue  <= pend_black ? 10'h000 : pix;
      end
    end
  end

endmodule

// File: tb/tb_edge_frame_reader.sv
// tb/tb_edge_frame_reader.sv - directed self-checking bench for edge_frame_reader
module tb_edge_frame_reader;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iFrameStart = 1'b0;
  logic        iPixReq = 1'b0;
  logic        oFifoRd;
  logic [15:0] iFifoData = 16'h0;
  logic        iFifoEmpty = 1'b0;
  logic [9:0]  oRed, oGreen, oBlue;
  logic        oDVAL;
  logic [1:0]  oX;
  logic [0:0]  oY;
  logic        oUnderflow;
  logic        oFrameDone;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  logic [11:0] fifo_mem [256];
  logic [7:0]  rd_ptr = 8'd0;

  int          rd_count   = 0;
  int          done_count = 0;
  int          done_cyc   = -1;
  logic [29:0] dval_rgb [$];
  int          dval_cyc [$];

  int first_req, last_req;

  edge_frame_reader #(.H_ACTIVE(4), .V_ACTIVE(2), .THRESH(12'd256)) dut (
    .iCLK(iCLK), .iRST(iRST), .iFrameStart(iFrameStart), .iPixReq(iPixReq),
    .oFifoRd(oFifoRd), .iFifoData(iFifoData), .iFifoEmpty(iFifoEmpty),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oDVAL(oDVAL),
    .oX(oX), .oY(oY), .oUnderflow(oUnderflow), .oFrameDone(oFrameDone)
  );

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cyc <= cyc + 1;

  // Normal-mode FIFO: word appears on the data bus the cycle after the strobe.
  always @(posedge iCLK) begin
    if (oFifoRd) begin
      iFifoData <= {4'hA, fifo_mem[rd_ptr]};
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  always @(negedge iCLK) begin
    #2;
    if (oFifoRd) rd_count = rd_count + 1;
    if (oFrameDone) begin
      done_count = done_count + 1;
      done_cyc   = cyc;
    end
    if (oDVAL) begin
      dval_rgb.push_back({oRed, oGreen, oBlue});
      dval_cyc.push_back(cyc);
    end
  end

  task automatic load_fifo(input logic [11:0] v0, v1, v2, v3, v4, v5, v6, v7);
    fifo_mem[rd_ptr]        = v0;
    fifo_mem[rd_ptr + 8'd1] = v1;
    fifo_mem[rd_ptr + 8'd2] = v2;
    fifo_mem[rd_ptr + 8'd3] = v3;
    fifo_mem[rd_ptr + 8'd4] = v4;
    fifo_mem[rd_ptr + 8'd5] = v5;
    fifo_mem[rd_ptr + 8'd6] = v6;
    fifo_mem[rd_ptr + 8'd7] = v7;
  endtask

  task automatic frame_start();
    @(negedge iCLK);
    iFrameStart = 1'b1;
    @(negedge iCLK);
    iFrameStart = 1'b0;
  endtask

  task automatic drive_reqs(input int n, input int empty_at);
    for (int i = 0; i < n; i++) begin
      @(negedge iCLK);
      iPixReq    = 1'b1;
      iFifoEmpty = (i == empty_at);
      if (i == 0) first_req = cyc;
      last_req = cyc;
    end
    @(negedge iCLK);
    iPixReq    = 1'b0;
    iFifoEmpty = 1'b0;
  endtask

  task automatic test_reset();
    iRST = 1'b0;
    repeat (3) @(negedge iCLK);
    iRST = 1'b1;
    #1;
    total++; if ({oRed, oGreen, oBlue} !== 30'h0) $display("FAIL reset_rgb got %h want 0", {oRed, oGreen, oBlue}); else passed++;
    total++; if ({oDVAL, oUnderflow, oFrameDone, oFifoRd} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {oDVAL, oUnderflow, oFrameDone, oFifoRd}); else passed++;
    total++; if ({oX, oY} !== 3'b0) $display("FAIL reset_xy got %b want 000", {oX, oY}); else passed++;
  endtask

  task automatic test_ignored(input string tag);
    int rd0 = rd_count;
    int dv0 = dval_rgb.size();
    drive_reqs(3, -1);
    repeat (3) @(negedge iCLK);
    #1;
    total++; if (rd_count - rd0 !== 0) $display("FAIL ignored_%s_rd got %0d want 0", tag, rd_count - rd0); else passed++;
    total++; if (dval_rgb.size() - dv0 !== 0) $display("FAIL ignored_%s_dval got %0d want 0", tag, dval_rgb.size() - dv0); else passed++;
    total++; if ({oX, oY} !== 3'b0) $display("FAIL ignored_%s_xy got %b want 000", tag, {oX, oY}); else passed++;
  endtask

  task automatic test_frame();
    logic [9:0] exp_pix [8] = '{10'h000, 10'h001, 10'h3FF, 10'h200, 10'h004, 10'h008, 10'h010, 10'h020};
    int rd0 = rd_count;
    int dv0 = dval_rgb.size();
    int dn0 = done_count;
    load_fifo(12'h000, 12'h004, 12'hFFF, 12'h800, 12'h010, 12'h020, 12'h040, 12'h080);
    frame_start();
    drive_reqs(8, -1);
    repeat (4) @(negedge iCLK);
    #3;
    total++; if (rd_count - rd0 !== 8) $display("FAIL frame_reads got %0d want 8", rd_count - rd0); else passed++;
    total++; if (dval_rgb.size() - dv0 !== 8) $display("FAIL frame_dval_count got %0d want 8", dval_rgb.size() - dv0); else passed++;
    if (dval_rgb.size() - dv0 == 8) begin
      for (int i = 0; i < 8; i++) begin
        total++; if (dval_rgb[dv0 + i] !== {3{exp_pix[i]}}) $display("FAIL frame_pix%0d got %h want %h", i, dval_rgb[dv0 + i], {3{exp_pix[i]}}); else passed++;
      end
      total++; if (dval_cyc[dv0] !== first_req + 2) $display("FAIL frame_latency_first got %0d want %0d", dval_cyc[dv0], first_req + 2); else passed++;
      total++; if (dval_cyc[dv0 + 7] !== first_req + 9) $display("FAIL frame_latency_last got %0d want %0d", dval_cyc[dv0 + 7], first_req + 9); else passed++;
    end
    total++; if (done_count - dn0 !== 1) $display("FAIL frame_done_pulses got %0d want 1", done_count - dn0); else passed++;
    total++; if (done_cyc !== last_req + 1) $display("FAIL frame_done_cycle got %0d want %0d", done_cyc, last_req + 1); else passed++;
    total++; if ({oX, oY} !== 3'b0) $display("FAIL frame_end_xy got %b want 000", {oX, oY}); else passed++;
  endtask

  task automatic test_underflow();
    logic [9:0] exp_pix [8] = '{10'h001, 10'h002, 10'h000, 10'h003, 10'h004, 10'h005, 10'h006, 10'h007};
    int rd0 = rd_count;
    int dv0 = dval_rgb.size();
    int dn0 = done_count;
    load_fifo(12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h018, 12'h01C, 12'h020);
    frame_start();
    total++; if (oUnderflow !== 1'b0) $display("FAIL underflow_initial got %b want 0", oUnderflow); else passed++;
    drive_reqs(8, 2);
    repeat (4) @(negedge iCLK);
    #3;
    total++; if (rd_count - rd0 !== 7) $display("FAIL underflow_reads got %0d want 7", rd_count - rd0); else passed++;
    total++; if (dval_rgb.size() - dv0 !== 8) $display("FAIL underflow_dval_count got %0d want 8", dval_rgb.size() - dv0); else passed++;
    if (dval_rgb.size() - dv0 == 8) begin
      for (int i = 0; i < 8; i++) begin
        total++; if (dval_rgb[dv0 + i] !== {3{exp_pix[i]}}) $display("FAIL underflow_pix%0d got %h want %h", i, dval_rgb[dv0 + i], {3{exp_pix[i]}}); else passed++;
      end
    end
    total++; if (oUnderflow !== 1'b1) $display("FAIL underflow_sticky got %b want 1", oUnderflow); else passed++;
    total++; if (done_count - dn0 !== 1) $display("FAIL underflow_done got %0d want 1", done_count - dn0); else passed++;
  endtask

  task automatic test_restart();
    int rd0, dv0, dn0, rcyc;
    load_fifo(12'h100, 12'h104, 12'h108, 12'h10C, 12'h110, 12'h114, 12'h118, 12'h11C);
    frame_start();
    rd0 = rd_count;
    dv0 = dval_rgb.size();
    for (int i = 0; i < 6; i++) begin
      @(negedge iCLK);
      iPixReq    = 1'b1;
      iFifoEmpty = (i == 0);
    end
    @(negedge iCLK);
    iFifoEmpty  = 1'b0;
    iFrameStart = 1'b1;
    rcyc = cyc;
    #1;
    total++; if ({oX, oY} !== {2'd2, 1'b1}) $display("FAIL restart_pos got %b want 101", {oX, oY}); else passed++;
    total++; if (oUnderflow !== 1'b1) $display("FAIL restart_uf_before got %b want 1", oUnderflow); else passed++;
    total++; if (oFifoRd !== 1'b0) $display("FAIL restart_req_ignored got %b want 0", oFifoRd); else passed++;
    @(negedge iCLK);
    iFrameStart = 1'b0;
    iPixReq     = 1'b0;
    #1;
    total++; if ({oX, oY, oUnderflow} !== 4'b0) $display("FAIL restart_cleared got %b want 0000", {oX, oY, oUnderflow}); else passed++;
    repeat (3) @(negedge iCLK);
    #3;
    total++; if (rd_count - rd0 !== 5) $display("FAIL restart_reads got %0d want 5", rd_count - rd0); else passed++;
    total++; if (dval_rgb.size() - dv0 !== 6) $display("FAIL restart_dval_count got %0d want 6", dval_rgb.size() - dv0); else passed++;
    if (dval_rgb.size() - dv0 == 6) begin
      total++; if (dval_cyc[dv0 + 5] !== rcyc + 1) $display("FAIL restart_inflight_cycle got %0d want %0d", dval_cyc[dv0 + 5], rcyc + 1); else passed++;
      total++; if (dval_rgb[dv0 + 5] !== {3{10'h044}}) $display("FAIL restart_inflight_pix got %h want %h", dval_rgb[dv0 + 5], {3{10'h044}}); else passed++;
    end
    load_fifo(12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0);
    dn0 = done_count;
    drive_reqs(8, -1);
    repeat (3) @(negedge iCLK);
    #3;
    total++; if (done_count - dn0 !== 1) $display("FAIL restart_full_frame_done got %0d want 1", done_count - dn0); else passed++;
  endtask

  task automatic test_reset_midframe();
    int dv0;
    load_fifo(12'hFFC, 12'hFFC, 12'hFFC, 12'hFFC, 12'h0, 12'h0, 12'h0, 12'h0);
    frame_start();
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLK);
      iPixReq = 1'b1;
    end
    @(negedge iCLK);
    iRST = 1'b0;
    #1;
    dv0 = dval_rgb.size();
    total++; if ({oDVAL, oFifoRd, oFrameDone, oUnderflow} !== 4'b0) $display("FAIL midreset_flags got %b want 0000", {oDVAL, oFifoRd, oFrameDone, oUnderflow}); else passed++;
    total++; if ({oRed, oGreen, oBlue} !== 30'h0) $display("FAIL midreset_rgb got %h want 0", {oRed, oGreen, oBlue}); else passed++;
    total++; if ({oX, oY} !== 3'b0) $display("FAIL midreset_xy got %b want 000", {oX, oY}); else passed++;
    @(negedge iCLK);
    iPixReq = 1'b0;
    @(negedge iCLK);
    iRST = 1'b1;
    repeat (4) @(negedge iCLK);
    #3;
    total++; if (dval_rgb.size() - dv0 !== 0) $display("FAIL midreset_no_dval got %0d want 0", dval_rgb.size() - dv0); else passed++;
  endtask

  task automatic test_colour();
    int dv0 = dval_rgb.size();
    logic [9:0] exp_pix [3];
`ifdef EDGE_THRESH_EN
    exp_pix = '{10'h000, 10'h3FF, 10'h3FF};
`else
    exp_pix = '{10'h03F, 10'h040, 10'h3FF};
`endif
    load_fifo(12'd255, 12'd256, 12'd4095, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0);
    frame_start();
    drive_reqs(3, -1);
    repeat (3) @(negedge iCLK);
    #3;
    total++; if (dval_rgb.size() - dv0 !== 3) $display("FAIL colour_count got %0d want 3", dval_rgb.size() - dv0); else passed++;
    if (dval_rgb.size() - dv0 == 3) begin
      for (int i = 0; i < 3; i++) begin
        total++; if (dval_rgb[dv0 + i] !== {3{exp_pix[i]}}) $display("FAIL colour_pix%0d got %h want %h", i, dval_rgb[dv0 + i], {3{exp_pix[i]}}); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ignored("idle");
    test_frame();
    test_ignored("done");
    test_underflow();
    test_restart();
    test_reset_midframe();
    test_colour();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
